// File: rtl/gpio_apbif_if.sv
// APB3 bus bundle between the fabric and the GPIO register file.
interface gpio_apbif_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [6:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/gpio_apbif.sv
// APB3 slave register file for the 8-bit GPIO port. Holds the software
// configuration driven to the GPIO core, emits one-cycle EOI pulses and
// returns core status. Zero wait states; prdata is captured at setup.
// Optional error responses are enabled with macro GPIO_APB_PSLVERR_EN.
module gpio_apbif #(
   parameter int unsigned GPIO_W   = 8,
   parameter logic [31:0] ID_VALUE = 32'h4750_0101
) (
   input  logic              pclk,
   input  logic              presetn,
   gpio_apbif_if.slave       apb,
   output logic [GPIO_W-1:0] gpio_swporta_dr,
   output logic [GPIO_W-1:0] gpio_swporta_ddr,
   output logic [GPIO_W-1:0] gpio_swporta_ctl,
   output logic [GPIO_W-1:0] gpio_inten,
   output logic [GPIO_W-1:0] gpio_intmask,
   output logic [GPIO_W-1:0] gpio_inttype_level,
   output logic [GPIO_W-1:0] gpio_int_polarity,
   output logic              gpio_ls_sync,
   output logic [GPIO_W-1:0] gpio_porta_eoi,
   input  logic [GPIO_W-1:0] gpio_ext_porta_rb,
   input  logic [GPIO_W-1:0] gpio_raw_intstatus,
   input  logic [GPIO_W-1:0] gpio_intr_int,
   input  logic              gpio_intr_flag_int,
   output logic              gpio_intr_flag
);

   // Word index (paddr[6:2]) of each mapped register.
   typedef enum logic [4:0] {
      A_DR      = 5'd0,
      A_DDR     = 5'd1,
      A_CTL     = 5'd2,
      A_INTEN   = 5'd12,
      A_INTMASK = 5'd13,
      A_INTTYPE = 5'd14,
      A_POL     = 5'd15,
      A_INTSTAT = 5'd16,
      A_RAWSTAT = 5'd17,
      A_EOI     = 5'd19,
      A_EXT     = 5'd20,
      A_LSSYNC  = 5'd24,
      A_ID      = 5'd27
   } reg_word_e;

   logic [GPIO_W-1:0] dr_q, dr_d, ddr_q, ddr_d, ctl_q, ctl_d;
   logic [GPIO_W-1:0] inten_q, inten_d, intmask_q, intmask_d;
   logic [GPIO_W-1:0] inttype_q, inttype_d, pol_q, pol_d;
   logic [GPIO_W-1:0] eoi_q, eoi_d;
   logic              ls_sync_q, ls_sync_d;
   logic              intr_flag_q, intr_flag_d;
   logic              pslverr_q, pslverr_d;
   logic [31:0]       prdata_q, prdata_d;

   logic [4:0]  word;
   logic        setup, wr_access, rd_setup;
   logic        mapped, ro;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign word        = apb.paddr[6:2];
   assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[31:GPIO_W]};

   // Bus phase qualifiers.
   always_comb begin
      setup     = apb.psel & ~apb.penable;
      wr_access = apb.psel & apb.penable & apb.pwrite;
      rd_setup  = setup & ~apb.pwrite;
   end

   // Address decode: mapped/read-only flags and read-data mux.
   always_comb begin
      mapped = 1'b0;
      ro     = 1'b0;
      rd_mux = '0;
      case (word)
         A_DR:      begin mapped = 1'b1; rd_mux = 32'(dr_q);      end
         A_DDR:     begin mapped = 1'b1; rd_mux = 32'(ddr_q);     end
         A_CTL:     begin mapped = 1'b1; rd_mux = 32'(ctl_q);     end
         A_INTEN:   begin mapped = 1'b1; rd_mux = 32'(inten_q);   end
         A_INTMASK: begin mapped = 1'b1; rd_mux = 32'(intmask_q); end
         A_INTTYPE: begin mapped = 1'b1; rd_mux = 32'(inttype_q); end
         A_POL:     begin mapped = 1'b1; rd_mux = 32'(pol_q);     end
         A_INTSTAT: begin mapped = 1'b1; ro = 1'b1; rd_mux = 32'(gpio_intr_int);      end
         A_RAWSTAT: begin mapped = 1'b1; ro = 1'b1; rd_mux = 32'(gpio_raw_intstatus); end
         A_EOI:     begin mapped = 1'b1; end
         A_EXT:     begin mapped = 1'b1; ro = 1'b1; rd_mux = 32'(gpio_ext_porta_rb);  end
         A_LSSYNC:  begin mapped = 1'b1; rd_mux = 32'(ls_sync_q); end
         A_ID:      begin mapped = 1'b1; ro = 1'b1; rd_mux = ID_VALUE; end
         default:   ;
      endcase
   end

   // Error response: captured at setup so it is valid for the whole access
   // cycle, then cleared by the access edge (penable is high there).
`ifdef GPIO_APB_PSLVERR_EN
   always_comb begin
      pslverr_d = setup & (~mapped | (apb.pwrite & ro));
   end
`else
   logic unused_err;
   assign unused_err = mapped | ro | setup;
   always_comb begin
      pslverr_d = 1'b0;
   end
`endif

   // Register writes on the access cycle, EOI pulse, read capture at setup.
   always_comb begin
      dr_d        = dr_q;
      ddr_d       = ddr_q;
      ctl_d       = ctl_q;
      inten_d     = inten_q;
      intmask_d   = intmask_q;
      inttype_d   = inttype_q;
      pol_d       = pol_q;
      ls_sync_d   = ls_sync_q;
      eoi_d       = '0;
      intr_flag_d = gpio_intr_flag_int;
      prdata_d    = rd_setup ? rd_mux : prdata_q;
      if (wr_access) begin
         case (word)
            A_DR:      dr_d      = apb.pwdata[GPIO_W-1:0];
            A_DDR:     ddr_d     = apb.pwdata[GPIO_W-1:0];
            A_CTL:     ctl_d     = apb.pwdata[GPIO_W-1:0];
            A_INTEN:   inten_d   = apb.pwdata[GPIO_W-1:0];
            A_INTMASK: intmask_d = apb.pwdata[GPIO_W-1:0];
            A_INTTYPE: inttype_d = apb.pwdata[GPIO_W-1:0];
            A_POL:     pol_d     = apb.pwdata[GPIO_W-1:0];
            A_EOI:     eoi_d     = apb.pwdata[GPIO_W-1:0];
            A_LSSYNC:  ls_sync_d = apb.pwdata[0];
            default:   ;
         endcase
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         dr_q        <= '0;
         ddr_q       <= '0;
         ctl_q       <= '0;
         inten_q     <= '0;
         intmask_q   <= '0;
         inttype_q   <= '0;
         pol_q       <= '0;
         ls_sync_q   <= 1'b0;
         eoi_q       <= '0;
         intr_flag_q <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
      end else begin
         dr_q        <= dr_d;
         ddr_q       <= ddr_d;
         ctl_q       <= ctl_d;
         inten_q     <= inten_d;
         intmask_q   <= intmask_d;
         inttype_q   <= inttype_d;
         pol_q       <= pol_d;
         ls_sync_q   <= ls_sync_d;
         eoi_q       <= eoi_d;
         intr_flag_q <= intr_flag_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
      end
   end

   assign apb.prdata         = prdata_q;
   assign apb.pready         = 1'b1;
   assign apb.pslverr        = pslverr_q;
   assign gpio_swporta_dr    = dr_q;
   assign gpio_swporta_ddr   = ddr_q;
   assign gpio_swporta_ctl   = ctl_q;
   assign gpio_inten         = inten_q;
   assign gpio_intmask       = intmask_q;
   assign gpio_inttype_level = inttype_q;
   assign gpio_int_polarity  = pol_q;
   assign gpio_ls_sync       = ls_sync_q;
   assign gpio_porta_eoi     = eoi_q;
   assign gpio_intr_flag     = intr_flag_q;

endmodule

// File: tb/tb_gpio_apbif.sv
// Self-checking bench for gpio_apbif: constant vector table, hand-written
// timing sequences and a randomized run against a register-map model.
module tb_gpio_apbif;

`ifdef GPIO_APB_PSLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [31:0] ID = 32'h4750_0101;

   logic       pclk = 1'b0;
   logic       presetn = 1'b0;
   logic [7:0] dr, ddr, ctl, inten, intmask, inttype, pol, eoi;
   logic       ls_sync, intr_flag;
   logic [7:0] ext_rb = '0, raw = '0, intr_int = '0;
   logic       flag_int = 1'b0;

   always #5 pclk = ~pclk;

   gpio_apbif_if pif ();

   gpio_apbif #(.GPIO_W(8), .ID_VALUE(ID)) dut (
      .pclk               (pclk),
      .presetn            (presetn),
      .apb                (pif),
      .gpio_swporta_dr    (dr),
      .gpio_swporta_ddr   (ddr),
      .gpio_swporta_ctl   (ctl),
      .gpio_inten         (inten),
      .gpio_intmask       (intmask),
      .gpio_inttype_level (inttype),
      .gpio_int_polarity  (pol),
      .gpio_ls_sync       (ls_sync),
      .gpio_porta_eoi     (eoi),
      .gpio_ext_porta_rb  (ext_rb),
      .gpio_raw_intstatus (raw),
      .gpio_intr_int      (intr_int),
      .gpio_intr_flag_int (flag_int),
      .gpio_intr_flag     (intr_flag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: byte-offset register map -------------
   logic [31:0] m_reg [0:127];

   function automatic logic [31:0] wmask(input logic [6:0] off);
      case (off)
         7'h00, 7'h04, 7'h08, 7'h30, 7'h34, 7'h38, 7'h3C: return 32'hFF;
         7'h60:   return 32'h1;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit is_ro(input logic [6:0] off);
      return off inside {7'h40, 7'h44, 7'h50, 7'h6C};
   endfunction

   function automatic bit is_mapped(input logic [6:0] off);
      return (wmask(off) != 0) || is_ro(off) || off == 7'h4C;
   endfunction

   function automatic bit model_err(input logic [6:0] off, input bit wr);
      if (!ERR_EN) return 1'b0;
      return !is_mapped(off) || (wr && is_ro(off));
   endfunction

   function automatic logic [31:0] model_read(input logic [6:0] off);
      case (off)
         7'h40:   return {24'h0, intr_int};
         7'h44:   return {24'h0, raw};
         7'h50:   return {24'h0, ext_rb};
         7'h6C:   return ID;
         default: return m_reg[int'(off)] & wmask(off);
      endcase
   endfunction

   task automatic model_write(input logic [6:0] off, input logic [31:0] d);
      if (!model_err(off, 1'b1)) m_reg[int'(off)] = d & wmask(off);
   endtask

   task automatic model_reset();
      for (int unsigned i = 0; i < 128; i++) m_reg[i] = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "/dr"},      {24'h0, dr},      m_reg[7'h00] & 32'hFF);
      check({tag, "/ddr"},     {24'h0, ddr},     m_reg[7'h04] & 32'hFF);
      check({tag, "/ctl"},     {24'h0, ctl},     m_reg[7'h08] & 32'hFF);
      check({tag, "/inten"},   {24'h0, inten},   m_reg[7'h30] & 32'hFF);
      check({tag, "/intmask"}, {24'h0, intmask}, m_reg[7'h34] & 32'hFF);
      check({tag, "/inttype"}, {24'h0, inttype}, m_reg[7'h38] & 32'hFF);
      check({tag, "/pol"},     {24'h0, pol},     m_reg[7'h3C] & 32'hFF);
      check({tag, "/ls_sync"}, {31'h0, ls_sync}, m_reg[7'h60] & 32'h1);
   endtask

   // ---------------- bus tasks: start and end on a falling edge ------------
   task automatic apb_write(input logic [6:0] a, input logic [31:0] d, output logic e);
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b1; pif.paddr = a; pif.pwdata = d;
      @(negedge pclk);
      pif.penable = 1'b1;
      e = pif.pslverr;
      @(negedge pclk);
      pif.psel = 1'b0; pif.penable = 1'b0;
   endtask

   task automatic apb_read(input logic [6:0] a, output logic [31:0] d, output logic e);
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b0; pif.paddr = a;
      @(negedge pclk);
      pif.penable = 1'b1;
      d = pif.prdata;
      e = pif.pslverr;
      @(negedge pclk);
      pif.psel = 1'b0; pif.penable = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
      string       name;
   } vec_t;

   function automatic vec_t mkv(input bit wr, input logic [6:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input bit er, input string nm);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er; v.name = nm;
      return v;
   endfunction

   localparam logic [6:0] OFFS [17] = '{7'h00, 7'h04, 7'h08, 7'h30, 7'h34, 7'h38, 7'h3C,
                                       7'h40, 7'h44, 7'h4C, 7'h50, 7'h60, 7'h6C,
                                       7'h0C, 7'h20, 7'h48, 7'h7C};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [$];
      logic [31:0] rd;
      logic        er;
      logic [6:0]  off;

      pif.psel = 1'b0; pif.penable = 1'b0; pif.pwrite = 1'b0; pif.paddr = '0; pif.pwdata = '0;
      model_reset();
      repeat (2) @(negedge pclk);
      check_outputs("rst_held");
      check("rst_held/eoi", {24'h0, eoi}, 32'h0);
      check("rst_held/pslverr", {31'h0, pif.pslverr}, 32'h0);
      check("rst_held/pready", {31'h0, pif.pready}, 32'h1);
      presetn = 1'b1;
      @(negedge pclk);

      // Read every offset after reset.
      foreach (OFFS[i]) begin
         apb_read(OFFS[i], rd, er);
         check($sformatf("rst_rd_%02h", OFFS[i]), rd, (OFFS[i] == 7'h6C) ? ID : 32'h0);
         check($sformatf("rst_err_%02h", OFFS[i]), {31'h0, er}, {31'h0, model_err(OFFS[i], 1'b0)});
      end

      // Constant vector table.
      raw = 8'h3C; intr_int = 8'h14; ext_rb = 8'h5A;
      tbl.push_back(mkv(1, 7'h00, 32'h0000_00A5, 0,           0,      "w_dr"));
      tbl.push_back(mkv(0, 7'h00, 0,             32'hA5,      0,      "r_dr"));
      tbl.push_back(mkv(1, 7'h04, 32'h0000_000F, 0,           0,      "w_ddr"));
      tbl.push_back(mkv(0, 7'h04, 0,             32'h0F,      0,      "r_ddr"));
      tbl.push_back(mkv(1, 7'h0B, 32'hFFFF_FF3C, 0,           0,      "w_ctl_lowbits"));
      tbl.push_back(mkv(0, 7'h08, 0,             32'h3C,      0,      "r_ctl"));
      tbl.push_back(mkv(1, 7'h60, 32'hFFFF_FFFE, 0,           0,      "w_ls0"));
      tbl.push_back(mkv(0, 7'h60, 0,             32'h0,       0,      "r_ls0"));
      tbl.push_back(mkv(1, 7'h60, 32'h0000_0001, 0,           0,      "w_ls1"));
      tbl.push_back(mkv(0, 7'h60, 0,             32'h1,       0,      "r_ls1"));
      tbl.push_back(mkv(0, 7'h44, 0,             32'h3C,      0,      "r_raw"));
      tbl.push_back(mkv(0, 7'h40, 0,             32'h14,      0,      "r_intstat"));
      tbl.push_back(mkv(0, 7'h50, 0,             32'h5A,      0,      "r_ext"));
      tbl.push_back(mkv(0, 7'h4C, 0,             32'h0,       0,      "r_eoi"));
      tbl.push_back(mkv(0, 7'h6C, 0,             ID,          0,      "r_id"));
      tbl.push_back(mkv(1, 7'h40, 32'hFF,        0,           ERR_EN, "w_ro_intstat"));
      tbl.push_back(mkv(0, 7'h40, 0,             32'h14,      0,      "r_intstat2"));
      tbl.push_back(mkv(0, 7'h20, 0,             32'h0,       ERR_EN, "r_unmapped"));
      tbl.push_back(mkv(1, 7'h20, 32'hFFFF,      0,           ERR_EN, "w_unmapped"));
      tbl.push_back(mkv(1, 7'h6C, 32'h0,         0,           ERR_EN, "w_ro_id"));
      tbl.push_back(mkv(0, 7'h6C, 0,             ID,          0,      "r_id2"));
      tbl.push_back(mkv(1, 7'h30, 32'h0000_00C3, 0,           0,      "w_inten"));
      tbl.push_back(mkv(0, 7'h30, 0,             32'hC3,      0,      "r_inten"));
      foreach (tbl[i]) begin
         off = {tbl[i].addr[6:2], 2'b00};
         if (tbl[i].wr) begin
            apb_write(tbl[i].addr, tbl[i].wdata, er);
            model_write(off, tbl[i].wdata);
            check_outputs(tbl[i].name);
         end else begin
            apb_read(tbl[i].addr, rd, er);
            check({tbl[i].name, "/rd"}, rd, tbl[i].exp_rd);
         end
         check({tbl[i].name, "/err"}, {31'h0, er}, {31'h0, tbl[i].exp_err});
         if (i == 0) check("w_dr/dr_out", {24'h0, dr}, 32'hA5);
         if (i == 2) check("w_ddr/ddr_out", {24'h0, ddr}, 32'h0F);
      end

      // Write becomes visible only after the access edge.
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b1; pif.paddr = 7'h00; pif.pwdata = 32'h77;
      @(negedge pclk); pif.penable = 1'b1;
      check("wr_timing/during_access", {24'h0, dr}, 32'hA5);
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      check("wr_timing/after_access", {24'h0, dr}, 32'h77);
      model_write(7'h00, 32'h77);

      // Status captured at the setup edge, held until the next read setup.
      raw = 8'h3C;
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b0; pif.paddr = 7'h44;
      @(negedge pclk); pif.penable = 1'b1;
      raw = 8'hFF;
      check("rd_sample/access", pif.prdata, 32'h3C);
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      check("rd_sample/hold", pif.prdata, 32'h3C);
      @(negedge pclk);
      check("rd_sample/hold_idle", pif.prdata, 32'h3C);

      // Interrupt flag is a one-cycle delay of the core flag.
      flag_int = 1'b1;
      check("flag/before", {31'h0, intr_flag}, 32'h0);
      @(negedge pclk);
      check("flag/set", {31'h0, intr_flag}, 32'h1);
      flag_int = 1'b0;
      @(negedge pclk);
      check("flag/clr", {31'h0, intr_flag}, 32'h0);

      // Back-to-back EOI writes give separate one-cycle pulses.
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b1; pif.paddr = 7'h4C; pif.pwdata = 32'h81;
      @(negedge pclk); pif.penable = 1'b1;
      check("eoi/none_yet", {24'h0, eoi}, 32'h0);
      @(negedge pclk);
      check("eoi/first", {24'h0, eoi}, 32'h81);
      pif.penable = 1'b0; pif.pwdata = 32'h02;
      @(negedge pclk); pif.penable = 1'b1;
      check("eoi/gap", {24'h0, eoi}, 32'h0);
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      check("eoi/second", {24'h0, eoi}, 32'h02);
      @(negedge pclk);
      check("eoi/cleared", {24'h0, eoi}, 32'h0);

      // Access cycle without setup: write commits, prdata unchanged.
      apb_read(7'h6C, rd, er);
      pif.psel = 1'b1; pif.penable = 1'b1; pif.pwrite = 1'b0; pif.paddr = 7'h00;
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      check("nosetup/rd_hold", pif.prdata, ID);
      pif.psel = 1'b1; pif.penable = 1'b1; pif.pwrite = 1'b1; pif.paddr = 7'h04; pif.pwdata = 32'h33;
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      model_write(7'h04, 32'h33);
      check("nosetup/wr", {24'h0, ddr}, 32'h33);

      // Reset asserted mid-access loses the pending write.
      flag_int = 1'b1;
      @(negedge pclk);
      pif.psel = 1'b1; pif.penable = 1'b0; pif.pwrite = 1'b1; pif.paddr = 7'h30; pif.pwdata = 32'hFF;
      @(negedge pclk); pif.penable = 1'b1;
      presetn = 1'b0;
      @(negedge pclk); pif.psel = 1'b0; pif.penable = 1'b0;
      model_reset();
      check_outputs("mid_rst");
      check("mid_rst/prdata", pif.prdata, 32'h0);
      check("mid_rst/flag", {31'h0, intr_flag}, 32'h0);
      presetn = 1'b1; flag_int = 1'b0;
      @(negedge pclk);
      apb_read(7'h30, rd, er);
      check("mid_rst/rd_inten", rd, 32'h0);

      // Randomized traffic against the model.
      for (int unsigned n = 0; n < 300; n++) begin
         logic        wr;
         logic [31:0] wd;
         raw      = 8'($urandom);
         intr_int = 8'($urandom);
         ext_rb   = 8'($urandom);
         flag_int = 1'($urandom);
         off = OFFS[$urandom_range(0, 16)];
         wr  = 1'($urandom);
         wd  = $urandom;
         if (wr) begin
            apb_write(off | 7'($urandom_range(0, 3)), wd, er);
            model_write(off, wd);
            check_outputs($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d/eoi", n), {24'h0, eoi},
                  (off == 7'h4C) ? (wd & 32'hFF) : 32'h0);
         end else begin
            apb_read(off | 7'($urandom_range(0, 3)), rd, er);
            check($sformatf("rnd%0d/rd_%02h", n, off), rd, model_read(off));
         end
         check($sformatf("rnd%0d/err", n), {31'h0, er}, {31'h0, model_err(off, wr)});
         check($sformatf("rnd%0d/flag", n), {31'h0, intr_flag}, {31'h0, flag_int});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_apbif.md
Name: gpio_apbif

Overview:
APB3 slave register file for the 8-bit GPIO port; the bus-facing counterpart of the GPIO controller core.
- Holds all software-programmed GPIO configuration (data, direction, control, interrupt enable/mask/type/polarity, level-sync) and drives it to the core.
- Generates one-cycle end-of-interrupt (EOI) pulses to the core.
- Returns core status (readback, raw and masked interrupt status) to software.
- Sits between the APB fabric and the GPIO controller core; all logic on pclk.

Parameters:
GPIO_W, 8, port width; only 8 supported with the existing core.
ID_VALUE, 32'h4750_0101, value returned at offset 0x6C.

Ports:
pclk  input  1  APB/GPIO clock
presetn  input  1  reset, asynchronous, active-low
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1=write, 0=read
paddr  input  7  byte address; bits [1:0] ignored
pwdata  input  32  write data
prdata  output  32  read data, registered
pready  output  1  always 1 (zero wait states)
pslverr  output  1  error response (see Optional Feature)
gpio_swporta_dr  output  8  data register to core
gpio_swporta_ddr  output  8  direction, 1=output
gpio_swporta_ctl  output  8  control/mode bits
gpio_inten  output  8  interrupt enable
gpio_intmask  output  8  interrupt mask, 1=masked
gpio_inttype_level  output  8  1=edge, 0=level
gpio_int_polarity  output  8  1=active-high/rising
gpio_ls_sync  output  1  level-interrupt synchroniser select
gpio_porta_eoi  output  8  EOI clear pulse, one pclk
gpio_ext_porta_rb  input  8  port readback from core
gpio_raw_intstatus  input  8  raw interrupt status from core
gpio_intr_int  input  8  masked interrupt status from core
gpio_intr_flag_int  input  1  OR of masked interrupts from core
gpio_intr_flag  output  1  registered interrupt flag to PLIC

Behaviour:
- Register map (offset, access):
  - 0x00 SWPORTA_DR RW[7:0]
  - 0x04 SWPORTA_DDR RW[7:0]
  - 0x08 SWPORTA_CTL RW[7:0]
  - 0x30 INTEN RW[7:0]
  - 0x34 INTMASK RW[7:0]
  - 0x38 INTTYPE_LEVEL RW[7:0]
  - 0x3C INT_POLARITY RW[7:0]
  - 0x40 INTSTATUS RO = gpio_intr_int
  - 0x44 RAW_INTSTATUS RO = gpio_raw_intstatus
  - 0x4C PORTA_EOI WO, reads 0
  - 0x50 EXT_PORTA RO = gpio_ext_porta_rb
  - 0x60 LS_SYNC RW[0]
  - 0x6C ID RO = ID_VALUE
- Unused read bits return 0. Unmapped offsets read 0; writes to them are ignored.
- Write commit:
  - Committed on the access cycle (psel & penable & pwrite).
  - Register updates at that pclk edge; the output is visible the next cycle.
  - Writes to RO offsets are ignored.
- Read:
  - Setup cycle (psel & ~penable & ~pwrite) registers the mux result into prdata.
  - prdata is valid throughout the access cycle and holds its value until the next read setup.
  - Status is sampled at the setup edge, not the access edge.
- EOI:
  - Access-phase write to 0x4C drives gpio_porta_eoi = pwdata[7:0] for exactly one pclk.
  - Returns to 0 the following cycle.
  - Back-to-back EOI writes each produce their own one-cycle pulse; there is no accumulation.
- gpio_intr_flag = gpio_intr_flag_int delayed one pclk.
- pready is constantly 1. A transaction is 2 cycles; there are no wait states.
- psel with penable but without a prior setup cycle is treated as a normal access cycle: write commits; prdata keeps its old value.
- Reset values:
  - All RW registers, prdata, gpio_porta_eoi, gpio_intr_flag and pslverr = 0.
  - Asynchronous assertion takes effect mid-transaction; any pending write is lost.
- Simultaneous events: none possible; there is a single bus port.
- The core's status reflects a register write one or more cycles later; software must tolerate this.

Optional Feature:
Macro GPIO_APB_PSLVERR_EN.
- Defined:
  - pslverr = 1 during the access cycle for any unmapped offset.
  - pslverr = 1 for a write to an RO offset (0x40, 0x44, 0x50, 0x6C).
  - pslverr is registered at setup and returns to 0 after the access cycle.
  - The erroring write has no effect; an erroring read returns 0.
- Not defined: pslverr tied to 0; the same accesses are silently ignored or read 0.

Test Plan:
- Reset, then read every offset → all RW read 0; 0x6C reads 32'h4750_0101; pslverr 0.
- Write 0xA5 to 0x00 and 0x0F to 0x04 → gpio_swporta_dr=8'hA5 and gpio_swporta_ddr=8'h0F one cycle after access; readback of each matches.
- Drive gpio_raw_intstatus=8'h3C and gpio_intr_int=8'h14, then read 0x44 and 0x40 → prdata 0x3C and 0x14 in the access phase. gpio_intr_flag_int=1 → gpio_intr_flag=1 one cycle later.
- Two consecutive writes of 0x81 then 0x02 to 0x4C → gpio_porta_eoi shows 8'h81 for one cycle, 0, then 8'h02 for one cycle. Reading 0x4C returns 0.
- Write 0xFF to 0x30, assert presetn low mid-access, release → gpio_inten=0 and no partial update.
- With GPIO_APB_PSLVERR_EN: write 0x40 → pslverr=1 in access cycle, INTSTATUS unaffected. Read 0x20 → pslverr=1, prdata 0. Without the macro: both pslverr=0.
